// File: rtl/if_queue.sv
// Instruction fetch queue: DEPTH-entry FWFT FIFO of {pc, instr} between fetch and decode.
// Latency: a push at edge N is visible on D_* after edge N; there is no same-cycle bypass.
// Backpressure: F_ready drops while full, even if a pop happens that cycle; empty outputs read as nop.
module if_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     F_valid,
   input  logic [31:0]              F_pc,
   input  logic [31:0]              F_instr,
   output logic                     F_ready,
   output logic                     D_valid,
   output logic [31:0]              D_pc,
   output logic [31:0]              D_instr,
   input  logic                     D_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;

   // Handshakes are decoded from registered count only, so a full queue
   // refuses a push even when decode drains the head in the same cycle.
   assign F_ready   = (count != CW'(DEPTH));
   assign D_valid   = (count != '0);
   assign push      = F_valid && F_ready;
   assign pop       = D_valid && D_ready;
   assign occupancy = count;
   assign D_pc      = D_valid ? mem[rd_ptr].pc    : 32'h0000_0000;
   assign D_instr   = D_valid ? mem[rd_ptr].instr : 32'h0000_0000;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: F_pc, instr: F_instr};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue at DEPTH=4: vector table plus hand sequences for streaming and flush timing.
module tb_if_queue;

   logic        clk;
   logic        reset;
   logic        F_valid;
   logic [31:0] F_pc;
   logic [31:0] F_instr;
   logic        F_ready;
   logic        D_valid;
   logic [31:0] D_pc;
   logic [31:0] D_instr;
   logic        D_ready;
   logic        flush;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;

   if_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .F_valid   (F_valid),
      .F_pc      (F_pc),
      .F_instr   (F_instr),
      .F_ready   (F_ready),
      .D_valid   (D_valid),
      .D_pc      (D_pc),
      .D_instr   (D_instr),
      .D_ready   (D_ready),
      .flush     (flush),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: run did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic fv,
                        input logic [31:0] pc, input logic dr);
      reset   = rst;
      flush   = fl;
      F_valid = fv;
      F_pc    = pc;
      F_instr = instr_of(pc);
      D_ready = dr;
   endtask

   task automatic check_out(input string tag, input logic [2:0] occ, input logic dv,
                            input logic [31:0] dpc, input logic fr);
      check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
      check({tag, ".D_valid"},   32'(D_valid),   32'(dv));
      check({tag, ".D_pc"},      D_pc,           dpc);
      check({tag, ".D_instr"},   D_instr,        dv ? instr_of(dpc) : 32'h0);
      check({tag, ".F_ready"},   32'(F_ready),   32'(fr));
   endtask

   typedef struct {
      logic        rst;
      logic        fl;
      logic        fv;
      logic [31:0] pc;
      logic        dr;
      logic [2:0]  occ;
      logic        dv;
      logic [31:0] dpc;
      logic        fr;
   } vec_t;

   vec_t vt [22];

   function automatic vec_t mk(input logic rst, input logic fl, input logic fv, input logic [31:0] pc,
                               input logic dr, input logic [2:0] occ, input logic dv,
                               input logic [31:0] dpc, input logic fr);
      vec_t v;
      v.rst = rst; v.fl = fl; v.fv = fv; v.pc = pc; v.dr = dr;
      v.occ = occ; v.dv = dv; v.dpc = dpc; v.fr = fr;
      return v;
   endfunction

   initial begin
      // Expected values are the outputs just after the edge on which the inputs are sampled.
      vt[0]  = mk(1, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1);
      vt[1]  = mk(0, 0, 1, 32'h3000, 0, 1, 1, 32'h3000, 1);
      vt[2]  = mk(0, 0, 1, 32'h3004, 0, 2, 1, 32'h3000, 1);
      vt[3]  = mk(0, 0, 1, 32'h3008, 0, 3, 1, 32'h3000, 1);
      vt[4]  = mk(0, 0, 1, 32'h300C, 0, 4, 1, 32'h3000, 0);
      vt[5]  = mk(0, 0, 1, 32'h3010, 0, 4, 1, 32'h3000, 0);
      vt[6]  = mk(0, 0, 1, 32'h3014, 0, 4, 1, 32'h3000, 0);
      vt[7]  = mk(0, 0, 1, 32'h3018, 1, 3, 1, 32'h3004, 1);
      vt[8]  = mk(0, 0, 0, 32'h0,    1, 2, 1, 32'h3008, 1);
      vt[9]  = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'h300C, 1);
      vt[10] = mk(0, 0, 0, 32'h0,    1, 0, 0, 32'h0,    1);
      vt[11] = mk(0, 0, 0, 32'h0,    1, 0, 0, 32'h0,    1);
      vt[12] = mk(0, 0, 1, 32'h3020, 1, 1, 1, 32'h3020, 1);
      vt[13] = mk(0, 0, 1, 32'h3024, 0, 2, 1, 32'h3020, 1);
      vt[14] = mk(0, 0, 1, 32'h3028, 0, 3, 1, 32'h3020, 1);
      vt[15] = mk(0, 1, 1, 32'h302C, 1, 0, 0, 32'h0,    1);
      vt[16] = mk(0, 0, 1, 32'h4000, 0, 1, 1, 32'h4000, 1);
      vt[17] = mk(0, 0, 1, 32'h4004, 0, 2, 1, 32'h4000, 1);
      vt[18] = mk(0, 0, 1, 32'h4008, 0, 3, 1, 32'h4000, 1);
      vt[19] = mk(0, 0, 1, 32'h400C, 0, 4, 1, 32'h4000, 0);
      vt[20] = mk(1, 1, 1, 32'h4010, 1, 0, 0, 32'h0,    1);
      vt[21] = mk(0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    1);

      drive(1, 0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(vt[i].rst, vt[i].fl, vt[i].fv, vt[i].pc, vt[i].dr);
         @(posedge clk);
         #1;
         check_out($sformatf("vec%0d", i), vt[i].occ, vt[i].dv, vt[i].dpc, vt[i].fr);
      end

      // Streaming: push and pop every cycle from empty; head trails fetch by one cycle.
      @(negedge clk);
      drive(0, 0, 1, 32'h5000, 1);
      #1;
      check("stream.no_bypass", 32'(D_valid), 32'd0);
      @(posedge clk);
      #1;
      check_out("stream0", 1, 1, 32'h5000, 1);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         drive(0, 0, 1, 32'h5000 + 32'(4 * i), 1);
         #1;
         check($sformatf("stream%0d.lag", i), D_pc, 32'h5000 + 32'(4 * (i - 1)));
         @(posedge clk);
         #1;
         check_out($sformatf("stream%0d", i), 1, 1, 32'h5000 + 32'(4 * i), 1);
      end
      @(negedge clk);
      drive(0, 0, 0, 32'h0, 1);
      @(posedge clk);
      #1;
      check_out("stream.drain", 0, 0, 32'h0, 1);

      // Flush cycle still shows pre-flush state; the flushed push is dropped.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 0, 1, 32'h6000 + 32'(4 * i), 0);
      end
      @(negedge clk);
      drive(0, 1, 1, 32'h600C, 1);
      #1;
      check_out("flush.pre", 3, 1, 32'h6000, 1);
      @(posedge clk);
      #1;
      check_out("flush.post", 0, 0, 32'h0, 1);
      @(negedge clk);
      drive(0, 0, 1, 32'h7000, 0);
      #1;
      check("flush.push_hidden", 32'(D_valid), 32'd0);
      @(posedge clk);
      #1;
      check_out("flush.repush", 1, 1, 32'h7000, 1);
      @(negedge clk);
      drive(0, 0, 0, 32'h0, 1);
      @(posedge clk);
      #1;
      check_out("flush.pop", 0, 0, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, entry count of the fetch queue (power of two, 2..16).
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- F_valid  input  1  fetch stage presents a valid {F_pc, F_instr} this cycle.
- F_pc  input  32  PC of the fetched instruction.
- F_instr  input  32  fetched instruction word.
- F_ready  output  1  queue accepts a push this cycle; drives the fetch unit's enable.
- D_valid  output  1  head entry is valid for decode.
- D_pc  output  32  PC of the head entry.
- D_instr  output  32  instruction of the head entry.
- D_ready  input  1  decode consumes the head this cycle; 0 means the D stage stalls.
- flush  input  1  redirect: discard all queued entries.
- occupancy  output  log2(DEPTH)+1  current entry count.
REQ-003 Clock and reset SHALL be the single clock clk and the synchronous active-high reset; there is no asynchronous reset path.

Function
REQ-004 The block SHALL store up to DEPTH {pc, instr} pairs in FIFO order using read pointer, write pointer and count registers.
REQ-005 A push SHALL occur when F_valid && F_ready; it writes {F_pc, F_instr} at the write pointer and advances the pointer modulo DEPTH.
REQ-006 A pop SHALL occur when D_valid && D_ready; it advances the read pointer modulo DEPTH.
REQ-007 F_ready SHALL equal (count != DEPTH), decoded from registered state only; a push into a full queue SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-008 D_valid SHALL equal (count != 0); D_pc and D_instr SHALL present the head entry combinationally (first-word fall-through).
REQ-009 When count == 0, D_pc and D_instr SHALL both be 32'h0000_0000 (nop).
REQ-010 Push-to-visible latency SHALL be one cycle: an entry pushed at edge N is on D_* after edge N; there is no same-cycle bypass from F_* to D_*.
REQ-011 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-012 A pop with count == 0 SHALL NOT be possible; D_ready while empty SHALL have no effect.
REQ-013 The count SHALL increment on push only, decrement on pop only, and stay within 0..DEPTH.
REQ-014 Pointer wrap-around SHALL be seamless: entry order is preserved across the DEPTH-1 -> 0 transition.
REQ-015 flush SHALL, at the next rising edge, clear count and both pointers; any push or pop in the flush cycle SHALL be discarded.
REQ-016 During the flush cycle, outputs SHALL still reflect the pre-flush state; after the edge D_valid=0 and F_ready=1.
REQ-017 occupancy SHALL equal the count register.
REQ-018 Storage contents SHALL NOT be reset or cleared; validity is defined solely by count and the pointers.

Reset
REQ-019 When reset=1 at a rising edge, count, read pointer and write pointer SHALL become 0, regardless of flush, F_valid or D_ready.
REQ-020 After reset: D_valid=0, D_pc=0, D_instr=0, F_ready=1, occupancy=0.
REQ-021 Reset asserted mid-operation (queue partially full) SHALL discard all entries in the same edge; reset takes priority over flush.

Verification
REQ-022 The bench SHALL cover these scenarios (DEPTH=4):
- Reset, then push pc 0x3000/0x3004/0x3008 with D_ready=0 -> occupancy 3, D_pc=0x3000, F_ready=1.
- Push 4 entries with D_ready=0, hold F_valid=1 -> F_ready=0 and occupancy stays 4; pops then yield 0x3000, 0x3004, 0x3008, 0x300C in order.
- Continuous push and pop for 10 cycles starting empty -> D_pc lags F_pc by one cycle, occupancy stays at 1, pointers wrap with no reordering.
- Queue at occupancy 3, flush=1 with F_valid=1 and D_ready=1 -> next cycle occupancy 0, D_valid=0, D_instr=0; next push (pc 0x4000) appears at the head one cycle later.
- Queue full, reset=1 together with flush=1 -> occupancy 0, F_ready=1, D_pc=0 after the edge.
- Full queue, D_ready=1 and F_valid=1 in the same cycle -> one pop, no push; occupancy 3 after the edge.
